// File: rtl/dac_pkg.sv
// Shared DAC constants and sampling state type, reused by the SoC top and DAC wrapper.
package dac_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned DIV_W  = 8;

  localparam logic [DATA_W-1:0] MID_CODE = DATA_W'(512);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one tick every div_value+1 cycles while run is high.
module sample_tick_gen
  import dac_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div_value,
  output logic             tick
);

  logic [DIV_W-1:0] count_q, count_d;
  logic             wrap;

  // ">=" rather than "==" so lowering div_value below the count wraps next cycle.
  always_comb begin
    wrap    = (count_q >= div_value);
    tick    = run & wrap;
    count_d = count_q + DIV_W'(1);
    if (!run || wrap) begin
      count_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dac_sample_arbiter.sv
// Round-robin arbiter sharing the DAC code register between the core and a test source.
module dac_sample_arbiter
  import dac_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_value,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] dac_code,
  output logic              sample_strobe,
  output logic              last_grant,
  output logic              underrun,
  input  logic              underrun_clr
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dac_code_q, dac_code_d;
  logic              strobe_q, strobe_d;
  logic              last_grant_q, last_grant_d;
  logic              underrun_q, underrun_d;

  logic run;
  logic tick;
  logic any_valid;
  logic grant;
  logic fire;

  // Gating with enable as well as the state keeps a tick that coincides with
  // enable falling from granting anything.
  assign run = (state_q == RUN) & enable;

  sample_tick_gen u_tick_gen (
    .CLK       (CLK),
    .reset     (reset),
    .run       (run),
    .div_value (div_value),
    .tick      (tick)
  );

  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    fire       = tick & any_valid;
    req0_ready = fire & ~grant;
    req1_ready = fire & grant;

    state_d      = enable ? RUN : IDLE;
    dac_code_d   = dac_code_q;
    strobe_d     = 1'b0;
    last_grant_d = last_grant_q;
    if (fire) begin
      dac_code_d   = grant ? req1_data : req0_data;
      strobe_d     = 1'b1;
      last_grant_d = grant;
    end

    // Set is applied after clear so a coincident underrun wins.
    underrun_d = underrun_q;
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (tick && !any_valid) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      dac_code_q   <= MID_CODE;
      strobe_q     <= 1'b0;
      last_grant_q <= 1'b1;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dac_code_q   <= dac_code_d;
      strobe_q     <= strobe_d;
      last_grant_q <= last_grant_d;
      underrun_q   <= underrun_d;
    end
  end

  assign dac_code      = dac_code_q;
  assign sample_strobe = strobe_q;
  assign last_grant    = last_grant_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_dac_sample_arbiter.sv
// Directed, table-driven bench for dac_sample_arbiter plus an async-reset sequence.
module tb_dac_sample_arbiter;

  logic       CLK = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] div_value;
  logic       req0_valid, req1_valid;
  logic [9:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [9:0] dac_code;
  logic       sample_strobe, last_grant, underrun, underrun_clr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       en;
    logic [7:0] div;
    logic       v0;
    logic [9:0] d0;
    logic       v1;
    logic [9:0] d1;
    logic       clr;
    logic       r0;
    logic       r1;
    logic [9:0] dac;
    logic       st;
    logic       lg;
    logic       ur;
  } vec_t;

  vec_t vecs[$];

  dac_sample_arbiter dut (
    .CLK           (CLK),
    .reset         (reset),
    .enable        (enable),
    .div_value     (div_value),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .dac_code      (dac_code),
    .sample_strobe (sample_strobe),
    .last_grant    (last_grant),
    .underrun      (underrun),
    .underrun_clr  (underrun_clr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic r0, input logic r1, input logic [9:0] dac,
                           input logic st, input logic lg, input logic ur);
    check("req0_ready", idx, 32'(req0_ready), 32'(r0));
    check("req1_ready", idx, 32'(req1_ready), 32'(r1));
    check("dac_code", idx, 32'(dac_code), 32'(dac));
    check("sample_strobe", idx, 32'(sample_strobe), 32'(st));
    check("last_grant", idx, 32'(last_grant), 32'(lg));
    check("underrun", idx, 32'(underrun), 32'(ur));
  endtask

  task automatic add(input logic en, input int div, input logic v0, input int d0, input logic v1,
                     input int d1, input logic clr, input logic r0, input logic r1, input int dac,
                     input logic st, input logic lg, input logic ur);
    vecs.push_back('{en, 8'(div), v0, 10'(d0), v1, 10'(d1), clr, r0, r1, 10'(dac), st, lg, ur});
  endtask

  task automatic drive(input logic en, input logic [7:0] div, input logic v0, input logic [9:0] d0,
                       input logic v1, input logic [9:0] d1, input logic clr);
    enable       = en;
    div_value    = div;
    req0_valid   = v0;
    req0_data    = d0;
    req1_valid   = v1;
    req1_data    = d1;
    underrun_clr = clr;
  endtask

  initial begin
    // Idle after reset.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h200, 0, 1, 0);
    // Single requester, period 4: ready on RUN cycles 4, 8, 12.
    add(1, 3, 1, 'h155, 0, 0, 0, 0, 0, 'h200, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 3, 1, 'h155, 0, 0, 0, 0, 0, 'h200, 0, 1, 0);
    add(1, 3, 1, 'h155, 0, 0, 0, 1, 0, 'h200, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      add(1, 3, 1, 'h155, 0, 0, 0, 0, 0, 'h155, 1, 0, 0);
      add(1, 3, 1, 'h155, 0, 0, 0, 0, 0, 'h155, 0, 0, 0);
      add(1, 3, 1, 'h155, 0, 0, 0, 0, 0, 'h155, 0, 0, 0);
      add(1, 3, 1, 'h155, 0, 0, 0, 1, 0, 'h155, 0, 0, 0);
    end
    // Lone req1 tick so contention starts from last_grant=1.
    add(1, 0, 0, 0, 1, 'h3FF, 0, 0, 1, 'h155, 1, 0, 0);
    // Contention every cycle: grants 0,1,0,1.
    add(1, 0, 1, 'h0AA, 1, 'h3FF, 0, 1, 0, 'h3FF, 1, 1, 0);
    add(1, 0, 1, 'h0AA, 1, 'h3FF, 0, 0, 1, 'h0AA, 1, 0, 0);
    add(1, 0, 1, 'h0AA, 1, 'h3FF, 0, 1, 0, 'h3FF, 1, 1, 0);
    add(1, 0, 1, 'h0AA, 1, 'h3FF, 0, 0, 1, 'h0AA, 1, 0, 0);
    // Underrun with period 3; clear coinciding with an empty tick loses.
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 'h3FF, 1, 1, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 1);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 1);
    add(1, 2, 0, 0, 0, 0, 1, 0, 0, 'h3FF, 0, 1, 1);
    add(1, 2, 0, 0, 0, 0, 1, 0, 0, 'h3FF, 0, 1, 1);
    add(1, 5, 0, 0, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 0);
    // Pause at count 2, then resume: tick on the 6th RUN cycle.
    add(0, 5, 1, 'h123, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 0);
    add(0, 5, 1, 'h123, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 0);
    add(1, 5, 1, 'h123, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(1, 5, 1, 'h123, 0, 0, 0, 0, 0, 'h3FF, 0, 1, 0);
    add(1, 5, 1, 'h123, 0, 0, 0, 1, 0, 'h3FF, 0, 1, 0);
    add(1, 5, 0, 0, 0, 0, 0, 0, 0, 'h123, 1, 0, 0);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_all(-1, 0, 0, 10'h200, 0, 1, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK);
      #1;
      drive(vecs[i].en, vecs[i].div, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].clr);
      @(negedge CLK);
      check_all(i, vecs[i].r0, vecs[i].r1, vecs[i].dac, vecs[i].st, vecs[i].lg, vecs[i].ur);
    end

    // Streaming contention, then async reset between edges.
    @(posedge CLK);
    #1;
    drive(1, 0, 1, 10'h0AA, 1, 10'h3FF, 0);
    @(negedge CLK);
    check("stream_req1_ready", 0, 32'(req1_ready), 32'd1);
    @(posedge CLK);
    #2;
    reset = 1'b0;
    #1;
    check_all(100, 0, 0, 10'h200, 0, 1, 0);
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    check("post_rst_idle_ready", 0, 32'(req0_ready | req1_ready), 32'd0);
    @(negedge CLK);
    check("post_rst_req0_ready", 0, 32'(req0_ready), 32'd1);
    check("post_rst_req1_ready", 0, 32'(req1_ready), 32'd0);
    @(negedge CLK);
    check_all(101, 0, 1, 10'h0AA, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
